// File: rtl/bcd_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_timer_ctrl : 3-digit BCD up/down timer with run/pause/load/terminal  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_timer_ctrl #(
  parameter int unsigned MAX_COUNT = 99,
  parameter bit          WRAP      = 1'b1
) (
  input  logic       slowclk_1hz,
  input  logic       RST,
  input  logic       run,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] preset_one,
  input  logic [3:0] preset_ten,
  input  logic [3:0] preset_hundred,
  output logic [3:0] one,
  output logic [3:0] ten,
  output logic [3:0] hundred,
  output logic       done,
  output logic       tc,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [11:0] c_max_bcd = {4'((MAX_COUNT / 100) % 10),
                                       4'((MAX_COUNT / 10) % 10),
                                       4'(MAX_COUNT % 10)};

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic        r_dir;
  logic        r_load;
  logic [11:0] r_preset;
  logic [11:0] w_cnt;
  logic [11:0] w_cnt_nxt;
  logic [11:0] w_preset_sat;
  logic [11:0] w_load_val;
  logic        w_at_term;
  logic        w_tc_nxt;

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] o;
    logic [3:0] t;
    logic [3:0] h;
    o = v[3:0];
    t = v[7:4];
    h = v[11:8];
    if (o == 4'd9) begin
      o = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {h, t, o};
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] o;
    logic [3:0] t;
    logic [3:0] h;
    o = v[3:0];
    t = v[7:4];
    h = v[11:8];
    if (o == 4'd0) begin
      o = 4'd9;
      if (t == 4'd0) begin
        t = 4'd9;
        h = (h == 4'd0) ? 4'd9 : h - 4'd1;
      end else begin
        t = t - 4'd1;
      end
    end else begin
      o = o - 4'd1;
    end
    return {h, t, o};
  endfunction

  assign w_cnt = {hundred, ten, one};
  assign state = r_state;

  // Packed BCD with valid digits orders the same as its decimal value,
  // so plain unsigned compares are safe for clamp and terminal detection.
  assign w_preset_sat = {sat_digit(r_preset[11:8]),
                         sat_digit(r_preset[7:4]),
                         sat_digit(r_preset[3:0])};
  assign w_load_val   = (w_preset_sat > c_max_bcd) ? c_max_bcd : w_preset_sat;
  assign w_at_term    = r_dir ? (w_cnt == 12'h000) : (w_cnt >= c_max_bcd);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt;
    w_tc_nxt    = 1'b0;
    if (r_load) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = w_load_val;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_run) w_state_nxt = RUN;
        end
        RUN: begin
          if (!r_run) begin
            w_state_nxt = PAUSE;
          end else if (w_at_term) begin
            if (WRAP) begin
              w_cnt_nxt = r_dir ? c_max_bcd : 12'h000;
              w_tc_nxt  = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end else begin
            w_cnt_nxt = r_dir ? bcd_dec(w_cnt) : bcd_inc(w_cnt);
          end
        end
        PAUSE: begin
          if (r_run) w_state_nxt = RUN;
        end
        DONE: begin
          if (!r_run) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    if (MAX_COUNT < 100) w_cnt_nxt[11:8] = 4'd0;
  end

  always_ff @(posedge slowclk_1hz or posedge RST) begin
    if (RST) begin
      r_run    <= 1'b0;
      r_dir    <= 1'b0;
      r_load   <= 1'b0;
      r_preset <= 12'h000;
      r_state  <= IDLE;
      one      <= 4'd0;
      ten      <= 4'd0;
      hundred  <= 4'd0;
      done     <= 1'b0;
      tc       <= 1'b0;
    end else begin
      r_run    <= run;
      r_dir    <= dir;
      r_load   <= load;
      r_preset <= {preset_hundred, preset_ten, preset_one};
      r_state  <= w_state_nxt;
      one      <= w_cnt_nxt[3:0];
      ten      <= w_cnt_nxt[7:4];
      hundred  <= w_cnt_nxt[11:8];
      done     <= (w_state_nxt == DONE);
      tc       <= w_tc_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

- Three-digit BCD count engine with run/pause, direction, preset load and terminal-count detection.
- Clocked by the 1 Hz tick domain.
- Replaces the free-running digit counter in front of the seven-segment display path. Its `one`/`ten`/`hundred` outputs feed the display decoders and anode mux directly.
- A small FSM decides when the count advances, holds, reloads or stops at terminal count.

## Interface
Parameters:
- `MAX_COUNT`, default 99: upper count limit, decimal, legal range 1..999.
- `WRAP`, default 1:
  - 1: terminal count wraps to the opposite end.
  - 0: terminal count stops in DONE.

Ports:
- `slowclk_1hz`, input, 1: count clock, all state updates on its rising edge.
- `RST`, input, 1: reset, asynchronous, active-high.
- `run`, input, 1: level switch; 1 = count, 0 = pause/stop.
- `dir`, input, 1: 0 = count up, 1 = count down.
- `load`, input, 1: level switch; 1 = load preset.
- `preset_one`, input, 4: preset units digit, BCD.
- `preset_ten`, input, 4: preset tens digit, BCD.
- `preset_hundred`, input, 4: preset hundreds digit, BCD.
- `one`, output, 4: units digit, BCD, registered.
- `ten`, output, 4: tens digit, BCD, registered.
- `hundred`, output, 4: hundreds digit, BCD, registered.
- `done`, output, 1: high while in DONE.
- `tc`, output, 1: one-cycle pulse on every wrap.
- `state`, output, 2: FSM code: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Reset value of outputs:
  - `one`/`ten`/`hundred` = 0.
  - `state` = IDLE.
  - `done` = 0, `tc` = 0.
- Switch inputs are registered once (one sample stage) before use. All decisions below use the registered values.
- Priority on each edge: `load` > state transitions > counting.
- Load (any state):
  - Any preset digit >9 is taken as 9.
  - The resulting value is clamped to `MAX_COUNT`.
  - Count ← clamped value, `state` → IDLE, `done` ← 0.
- IDLE:
  - `run`=1 → RUN; count unchanged on the transition edge.
  - Otherwise hold.
- RUN:
  - `run`=0 → PAUSE, count held.
  - Otherwise count steps by one per edge: +1 if `dir`=0, −1 if `dir`=1.
- Terminal value is `MAX_COUNT` when counting up and 0 when counting down. When the count equals the terminal value at an edge in RUN:
  - `WRAP`=1: count ← opposite end (0 for up, `MAX_COUNT` for down), `tc`=1 for that cycle, stay in RUN.
  - `WRAP`=0: count held, `state` → DONE, `done` ← 1.
- PAUSE:
  - `run`=1 → RUN; first step on the following edge.
  - Otherwise hold.
- DONE:
  - Count held.
  - `run`=0 → IDLE with count kept, `done` ← 0.
  - `load` → IDLE with preset.
- A `dir` change while in RUN takes effect on the next edge. The terminal value follows the new `dir`.
- Arithmetic:
  - Per-digit BCD with ripple carry (up) and borrow (down).
  - Digits are always 0..9; no binary intermediate is exposed.
  - `hundred` is held at 0 when `MAX_COUNT` < 100.
- Reset mid-operation: all registers return to reset values immediately. The first post-reset edge behaves as IDLE.

## Timing
- Input-to-effect latency: 2 edges (sample stage + FSM/count update). Example: `run` rising before edge N gives RUN at edge N+1 and the first step at edge N+2.
- Count outputs, `done`, `state` and `tc` are all registered: valid after the rising edge, stable for the full 1 s period.
- `tc` is high for exactly one `slowclk_1hz` cycle per wrap. It is never asserted when `WRAP`=0.
- `load` held high keeps reloading each edge and blocks counting. When `load` and `run` are high on the same edge, the load wins; RUN is entered on the edge after `load` falls.

## Test plan
- Reset with `run`=1:
  - Release → digits 000, `state`=00.
  - `state`=01 at edge 2; digits 001 at edge 3; 002 at edge 4.
- Wrap up, `MAX_COUNT`=99, `WRAP`=1, `dir`=0:
  - Preset 098, run → 099 then 000.
  - `tc` pulses exactly once, on the 099→000 edge.
  - Carry ripples correctly through 009→010.
- Wrap down, `dir`=1:
  - Preset 002, run → 001, 000, 099 (`tc` pulse), 098.
  - Borrow checks: 010→009 and 100→099 (run with `MAX_COUNT`=999).
- Stop at terminal, `WRAP`=0, `dir`=1:
  - Preset 003 → 002, 001, 000, then `state`=11, `done`=1, digits held at 000 for ≥3 edges.
  - `run`=0 → IDLE, `done`=0.
- Pause and clamp:
  - Drop `run` at 045 → `state`=10, holds 045; restore `run` → 046 two edges later.
  - Preset 1/5/7 digits with `MAX_COUNT`=99 → clamped to 099.
  - Preset digit 4'hC → taken as 9.
- Asynchronous reset:
  - Assert `RST` mid-RUN at count 057, between clock edges → outputs 000, `done`=0, `tc`=0 immediately, before the next edge.
